// File: rtl/l1_dcache_miss_ctrl_if.sv
// Signal bundle between the L1 dcache miss handler and the pipeline, tag/data RAM and L2.
// master: miss handler side; slave: surrounding cache/L2 side.
interface l1_dcache_miss_ctrl_if #(
  parameter int TAG_W  = 21,
  parameter int IDX_W  = 8,
  parameter int LINE_W = 128
);
  logic              miss_req;
  logic [TAG_W-1:0]  miss_tag;
  logic [IDX_W-1:0]  miss_index;
  logic              busy;
  logic              done;
  logic              tag0_rw;
  logic              tag1_rw;
  logic              dirty0_rw;
  logic              dirty1_rw;
  logic              dirty_wd;
  logic [IDX_W-1:0]  index;
  logic [TAG_W-1:0]  tag_wd;
  logic [3:0]        wr0_en;
  logic [3:0]        wr1_en;
  logic              data_wd_l2_en;
  logic [LINE_W-1:0] data_wd_l2;
  logic [TAG_W-1:0]  tag0_rd;
  logic [TAG_W-1:0]  tag1_rd;
  logic              dirty0;
  logic              dirty1;
  logic              lru;
  logic              complete;
  logic [LINE_W-1:0] data0_rd;
  logic [LINE_W-1:0] data1_rd;
  logic              l2_rd_req;
  logic [TAG_W+IDX_W-1:0] l2_rd_addr;
  logic              l2_rd_rdy;
  logic [LINE_W-1:0] l2_rd_data;
  logic              l2_wr_req;
  logic [TAG_W+IDX_W-1:0] l2_wr_addr;
  logic [LINE_W-1:0] l2_wr_data;
  logic              l2_wr_ack;

  modport master (
    input  miss_req, miss_tag, miss_index,
    input  tag0_rd, tag1_rd, dirty0, dirty1, lru, complete,
    input  data0_rd, data1_rd,
    input  l2_rd_rdy, l2_rd_data, l2_wr_ack,
    output busy, done,
    output tag0_rw, tag1_rw, dirty0_rw, dirty1_rw, dirty_wd,
    output index, tag_wd, wr0_en, wr1_en,
    output data_wd_l2_en, data_wd_l2,
    output l2_rd_req, l2_rd_addr,
    output l2_wr_req, l2_wr_addr, l2_wr_data
  );

  modport slave (
    output miss_req, miss_tag, miss_index,
    output tag0_rd, tag1_rd, dirty0, dirty1, lru, complete,
    output data0_rd, data1_rd,
    output l2_rd_rdy, l2_rd_data, l2_wr_ack,
    input  busy, done,
    input  tag0_rw, tag1_rw, dirty0_rw, dirty1_rw, dirty_wd,
    input  index, tag_wd, wr0_en, wr1_en,
    input  data_wd_l2_en, data_wd_l2,
    input  l2_rd_req, l2_rd_addr,
    input  l2_wr_req, l2_wr_addr, l2_wr_data
  );
endinterface

// File: rtl/l1_dcache_miss_ctrl.sv
// L1 dcache miss handler: victim writeback, L2 line fill, tag/data install.
// DCACHE_WB_BUF_EN adds a one-entry writeback buffer overlapping WB with the fill.
module l1_dcache_miss_ctrl #(
  parameter int TAG_W  = 21,
  parameter int IDX_W  = 8,
  parameter int LINE_W = 128
) (
  input logic clk,
  input logic reset,
  l1_dcache_miss_ctrl_if.master bus
);
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] LOOKUP   = 3'd1;
  localparam logic [2:0] WB       = 3'd2;
  localparam logic [2:0] FILL     = 3'd3;
  localparam logic [2:0] WRITE    = 3'd4;
  localparam logic [2:0] WAIT_CMP = 3'd5;
  localparam logic [2:0] DONE     = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [TAG_W-1:0]  tag_q, vtag_q;
  logic [IDX_W-1:0]  idx_q;
  logic [LINE_W-1:0] vline_q, fill_q;
  logic              way_q;
  logic              rd_req_q;
  logic              wr_req_q, wr_req_d;
  logic              accept, vdirty, wr_st;

  assign vdirty = bus.lru ? bus.dirty1 : bus.dirty0;

`ifdef DCACHE_WB_BUF_EN
  // wr_req_q doubles as the buffer valid bit; no new miss until drained
  assign accept   = bus.miss_req && !wr_req_q;
  assign wr_req_d = (state_q == LOOKUP && vdirty)
                  || (wr_req_q && !bus.l2_wr_ack);
`else
  assign accept   = bus.miss_req;
  assign wr_req_d = (state_d == WB);
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (accept) state_d = LOOKUP;
`ifdef DCACHE_WB_BUF_EN
      LOOKUP:   state_d = FILL;
`else
      LOOKUP:   state_d = vdirty ? WB : FILL;
`endif
      WB:       if (bus.l2_wr_ack) state_d = FILL;
      FILL:     if (bus.l2_rd_rdy) state_d = WRITE;
      WRITE:    state_d = WAIT_CMP;
      WAIT_CMP: if (bus.complete) state_d = DONE;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      tag_q    <= '0;
      idx_q    <= '0;
      vtag_q   <= '0;
      vline_q  <= '0;
      fill_q   <= '0;
      way_q    <= 1'b0;
      rd_req_q <= 1'b0;
      wr_req_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_req_q <= (state_d == FILL);
      wr_req_q <= wr_req_d;
      if (state_q == IDLE && accept) begin
        tag_q <= bus.miss_tag;
        idx_q <= bus.miss_index;
      end
      if (state_q == LOOKUP) begin
        way_q   <= bus.lru;
        vtag_q  <= bus.lru ? bus.tag1_rd : bus.tag0_rd;
        vline_q <= bus.lru ? bus.data1_rd : bus.data0_rd;
      end
      if (state_q == FILL && bus.l2_rd_rdy)
        fill_q <= bus.l2_rd_data;
    end
  end

  assign wr_st = (state_q == WRITE);

  assign bus.busy = (state_q != IDLE && state_q != DONE)
                  || wr_req_q;
  assign bus.done = (state_q == DONE);

  assign bus.tag0_rw   = wr_st && !way_q;
  assign bus.tag1_rw   = wr_st && way_q;
  assign bus.dirty0_rw = wr_st && !way_q;
  assign bus.dirty1_rw = wr_st && way_q;
  assign bus.dirty_wd  = 1'b0;
  assign bus.wr0_en    = {4{wr_st && !way_q}};
  assign bus.wr1_en    = {4{wr_st && way_q}};

  assign bus.index         = idx_q;
  assign bus.tag_wd        = tag_q;
  assign bus.data_wd_l2_en = wr_st;
  assign bus.data_wd_l2    = fill_q;

  assign bus.l2_rd_req  = rd_req_q;
  assign bus.l2_rd_addr = {tag_q, idx_q};
  assign bus.l2_wr_req  = wr_req_q;
  assign bus.l2_wr_addr = {vtag_q, idx_q};
  assign bus.l2_wr_data = vline_q;
endmodule

// File: tb/tb_l1_dcache_miss_ctrl.sv
// Directed bench for l1_dcache_miss_ctrl: clean/dirty misses, held request, reset, slow complete.
// Define DCACHE_WB_BUF_EN to exercise the writeback-buffer build instead of serialized WB.
module tb_l1_dcache_miss_ctrl;
  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;
  int   done_cnt;
  int   wr_cnt;
  int   d0;

  l1_dcache_miss_ctrl_if #(.TAG_W(21), .IDX_W(8), .LINE_W(128)) bus ();

  l1_dcache_miss_ctrl #(.TAG_W(21), .IDX_W(8), .LINE_W(128)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.done) done_cnt++;
    if (bus.l2_wr_req) wr_cnt++;
  end

  task automatic check(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobes_low(input string tag);
    check(tag, {bus.tag0_rw, bus.tag1_rw, bus.dirty0_rw, bus.dirty1_rw,
                bus.data_wd_l2_en, bus.wr0_en, bus.wr1_en}, '0);
  endtask

  // clean miss on way 0; rdy after rdy_dly FILL cycles, complete after cmp_dly WAIT_CMP cycles
  task automatic clean_miss(input logic [20:0] t, input logic [7:0] ix,
                            input logic [127:0] line, input int rdy_dly,
                            input int cmp_dly);
    d0 = done_cnt;
    wr_cnt = 0;
    bus.lru = 1'b0;
    bus.dirty0 = 1'b0;
    bus.miss_tag = t;
    bus.miss_index = ix;
    bus.miss_req = 1'b1;
    step();
    bus.miss_req = 1'b0;
    check("lkp_busy", bus.busy, 1'b1);
    check("lkp_index", bus.index, ix);
    step();
    check("fill_rd_req", bus.l2_rd_req, 1'b1);
    check("fill_rd_addr", bus.l2_rd_addr, {t, ix});
    repeat (rdy_dly) step();
    check("fill_hold", bus.l2_rd_req, 1'b1);
    bus.l2_rd_rdy = 1'b1;
    bus.l2_rd_data = line;
    step();
    bus.l2_rd_rdy = 1'b0;
    bus.l2_rd_data = '0;
    check("wr_tag0_rw", bus.tag0_rw, 1'b1);
    check("wr_dirty0_rw", bus.dirty0_rw, 1'b1);
    check("wr_tag1_rw", bus.tag1_rw, 1'b0);
    check("wr_wr0_en", bus.wr0_en, 4'hF);
    check("wr_wr1_en", bus.wr1_en, 4'h0);
    check("wr_dirty_wd", bus.dirty_wd, 1'b0);
    check("wr_tag_wd", bus.tag_wd, t);
    check("wr_l2_en", bus.data_wd_l2_en, 1'b1);
    check("wr_data", bus.data_wd_l2, line);
    check("wr_rd_req", bus.l2_rd_req, 1'b0);
    step();
    for (int i = 0; i < cmp_dly; i++) begin
      strobes_low("wait_strobes");
      check("wait_done", bus.done, 1'b0);
      step();
    end
    strobes_low("cmp_strobes");
    bus.complete = 1'b1;
    step();
    bus.complete = 1'b0;
    check("done_pulse", bus.done, 1'b1);
    check("done_busy", bus.busy, 1'b0);
    step();
    check("done_clr", bus.done, 1'b0);
    check("done_once", done_cnt - d0, 1);
    check("clean_no_wr", wr_cnt, 0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    done_cnt = 0;
    wr_cnt = 0;
    reset = 1'b0;
    bus.miss_req = 1'b0;
    bus.miss_tag = '0;
    bus.miss_index = '0;
    bus.tag0_rd = '0;
    bus.tag1_rd = '0;
    bus.dirty0 = 1'b0;
    bus.dirty1 = 1'b0;
    bus.lru = 1'b0;
    bus.complete = 1'b0;
    bus.data0_rd = '0;
    bus.data1_rd = '0;
    bus.l2_rd_rdy = 1'b0;
    bus.l2_rd_data = '0;
    bus.l2_wr_ack = 1'b0;
    #2;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_rd_req", bus.l2_rd_req, 1'b0);
    check("rst_wr_req", bus.l2_wr_req, 1'b0);
    check("rst_addr", {bus.l2_rd_addr, bus.l2_wr_addr, bus.index}, '0);
    check("rst_data", bus.data_wd_l2, '0);
    check("rst_wdata", bus.l2_wr_data, '0);
    strobes_low("rst_strobes");
    step();
    reset = 1'b1;
    step();

    // clean miss: rdy after 3 cycles, complete right after WRITE
    clean_miss(21'h1A5, 8'h3C, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 3, 0);

`ifndef DCACHE_WB_BUF_EN
    // dirty victim in way 1: serialized writeback before fill
    bus.lru = 1'b1;
    bus.dirty1 = 1'b1;
    bus.tag1_rd = 21'h0F0;
    bus.data1_rd = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
    bus.miss_tag = 21'h2AA;
    bus.miss_index = 8'h55;
    bus.miss_req = 1'b1;
    step();
    bus.miss_req = 1'b0;
    step();
    bus.tag1_rd = 21'h1FFFFF;
    bus.data1_rd = '1;
    check("wb_req", bus.l2_wr_req, 1'b1);
    check("wb_addr", bus.l2_wr_addr, {21'h0F0, 8'h55});
    check("wb_data", bus.l2_wr_data, 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF);
    check("wb_no_rd", bus.l2_rd_req, 1'b0);
    step();
    check("wb_hold", bus.l2_wr_req, 1'b1);
    bus.l2_wr_ack = 1'b1;
    step();
    bus.l2_wr_ack = 1'b0;
    check("wb_drop", bus.l2_wr_req, 1'b0);
    check("wb_fill_req", bus.l2_rd_req, 1'b1);
    check("wb_fill_addr", bus.l2_rd_addr, {21'h2AA, 8'h55});
    bus.l2_rd_rdy = 1'b1;
    bus.l2_rd_data = 128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA;
    step();
    bus.l2_rd_rdy = 1'b0;
    check("wb_tag1_rw", bus.tag1_rw, 1'b1);
    check("wb_tag0_rw", bus.tag0_rw, 1'b0);
    check("wb_wr1_en", bus.wr1_en, 4'hF);
    check("wb_wr0_en", bus.wr0_en, 4'h0);
    check("wb_tag_wd", bus.tag_wd, 21'h2AA);
    check("wb_wdata", bus.data_wd_l2, 128'h5555_AAAA_5555_AAAA_5555_AAAA_5555_AAAA);
    step();
    bus.complete = 1'b1;
    step();
    bus.complete = 1'b0;
    check("wb_done", bus.done, 1'b1);
    step();
    bus.dirty1 = 1'b0;
    bus.lru = 1'b0;
`else
    // dirty victim with writeback buffer; ack arrives after the line is installed
    wr_cnt = 0;
    bus.lru = 1'b1;
    bus.dirty1 = 1'b1;
    bus.tag1_rd = 21'h0F0;
    bus.data1_rd = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
    bus.miss_tag = 21'h2AA;
    bus.miss_index = 8'h55;
    bus.miss_req = 1'b1;
    step();
    bus.miss_req = 1'b0;
    step();
    check("buf_rd_req", bus.l2_rd_req, 1'b1);
    check("buf_wr_req", bus.l2_wr_req, 1'b1);
    check("buf_wr_addr", bus.l2_wr_addr, {21'h0F0, 8'h55});
    check("buf_wr_data", bus.l2_wr_data, 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF);
    bus.l2_rd_rdy = 1'b1;
    bus.l2_rd_data = 128'h77;
    step();
    bus.l2_rd_rdy = 1'b0;
    check("buf_wr1_en", bus.wr1_en, 4'hF);
    step();
    bus.complete = 1'b1;
    step();
    bus.complete = 1'b0;
    check("buf_done", bus.done, 1'b1);
    check("buf_done_busy", bus.busy, 1'b1);
    check("buf_done_wr", bus.l2_wr_req, 1'b1);
    bus.miss_req = 1'b1;
    step();
    check("buf_idle_busy", bus.busy, 1'b1);
    step();
    check("buf_refused", bus.l2_rd_req | bus.done, 1'b0);
    bus.miss_req = 1'b0;
    bus.l2_wr_ack = 1'b1;
    step();
    bus.l2_wr_ack = 1'b0;
    check("buf_drained", bus.l2_wr_req, 1'b0);
    check("buf_busy_clr", bus.busy, 1'b0);
    step();
    bus.dirty1 = 1'b0;
    bus.lru = 1'b0;
`endif

    // miss_req held high: one transaction, then a second from IDLE
    d0 = done_cnt;
    bus.lru = 1'b0;
    bus.dirty0 = 1'b0;
    bus.miss_tag = 21'h00C;
    bus.miss_index = 8'h01;
    bus.miss_req = 1'b1;
    step();
    step();
    bus.l2_rd_rdy = 1'b1;
    step();
    bus.l2_rd_rdy = 1'b0;
    check("hold_write", bus.wr0_en, 4'hF);
    step();
    bus.complete = 1'b1;
    step();
    bus.complete = 1'b0;
    check("hold_done", bus.done, 1'b1);
    step();
    check("hold_idle", bus.busy, 1'b0);
    check("hold_one_done", done_cnt - d0, 1);
    step();
    bus.miss_req = 1'b0;
    check("hold_second", bus.busy, 1'b1);
    step();
    bus.l2_rd_rdy = 1'b1;
    step();
    bus.l2_rd_rdy = 1'b0;
    step();
    bus.complete = 1'b1;
    step();
    bus.complete = 1'b0;
    step();
    check("hold_two_done", done_cnt - d0, 2);

    // reset asserted in FILL
    d0 = done_cnt;
    bus.miss_tag = 21'h111;
    bus.miss_index = 8'h22;
    bus.miss_req = 1'b1;
    step();
    bus.miss_req = 1'b0;
    step();
    check("pre_rst_rd", bus.l2_rd_req, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_rd_req", bus.l2_rd_req, 1'b0);
    check("arst_busy", bus.busy, 1'b0);
    check("arst_addr", bus.l2_rd_addr, '0);
    check("arst_index", bus.index, '0);
    #1;
    reset = 1'b1;
    step();
    step();
    check("arst_no_done", done_cnt - d0, 0);
    clean_miss(21'h0AB, 8'hC3, 128'hCAFE, 0, 0);

    // complete held off for 10 cycles
    clean_miss(21'h1F0F0, 8'hFF, 128'h1234_5678, 1, 10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
